// File: rtl/video_mono_pkg.sv
// Shared encodings, luma coefficients and dither table for the monochrome video path.
package video_mono_pkg;

    localparam int unsigned MODE_W     = 3;
    localparam int unsigned COEF_R     = 54;
    localparam int unsigned COEF_G     = 183;
    localparam int unsigned COEF_B     = 18;
    localparam int unsigned LUMA_SHIFT = 8;
    localparam int unsigned LAT        = 3;
    localparam int unsigned BAYER_W    = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_COLOR   = 3'd0,
        MODE_GREEN   = 3'd1,
        MODE_AMBER   = 3'd2,
        MODE_WHITE   = 3'd3,
        MODE_INVERSE = 3'd4
    } mode_e;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } sync_t;

    // 2x2 ordered-dither threshold indexed by {py, px}
    function automatic logic [BAYER_W-1:0] bayer_thresh(input logic py, input logic px);
        logic [BAYER_W-1:0] t;
        case ({py, px})
            2'b00:   t = 2'd0;
            2'b01:   t = 2'd2;
            2'b10:   t = 2'd3;
            default: t = 2'd1;
        endcase
        return t;
    endfunction

    // Unused request codes fall back to colour
    function automatic mode_e map_mode(input logic [MODE_W-1:0] m);
        mode_e r;
        case (m)
            3'd1:    r = MODE_GREEN;
            3'd2:    r = MODE_AMBER;
            3'd3:    r = MODE_WHITE;
            3'd4:    r = MODE_INVERSE;
            default: r = MODE_COLOR;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/video_mono_filter_trunc.sv
// One colour channel: add dither threshold, saturate at full scale, drop low bits.
module mono_dither_trunc #(
    parameter int unsigned CW = 6,
    parameter int unsigned OW = 3
) (
    input  logic [CW-1:0] c_in,
    input  logic [CW-1:0] t_in,
    input  logic          blank_in,
    output logic [OW-1:0] c_out_c
);

    logic [CW:0]   sum_c;
    logic [CW-1:0] sat_c;

    // Carry out of the add means the value clipped; clamp instead of wrapping
    always_comb begin
        sum_c   = {1'b0, c_in} + {1'b0, t_in};
        sat_c   = sum_c[CW] ? '1 : sum_c[CW-1:0];
        c_out_c = blank_in ? '0 : OW'(sat_c >> (CW - OW));
    end

endmodule

// File: rtl/video_mono_filter.sv
// Three-stage colour/phosphor-look converter with frame-aligned mode switching and 2x2 dither.
module video_mono_filter
    import video_mono_pkg::*;
#(
    parameter int unsigned CW       = 6,
    parameter int unsigned OW       = 3,
    parameter int unsigned DITHER   = 1,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic              clk_vga,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic [CW-1:0]     r_in,
    input  logic [CW-1:0]     g_in,
    input  logic [CW-1:0]     b_in,
    input  logic              de_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic [OW-1:0]     r_out,
    output logic [OW-1:0]     g_out,
    output logic [OW-1:0]     b_out,
    output logic              de_out,
    output logic              hs_out,
    output logic              vs_out,
    output logic [MODE_W-1:0] mode_cur
);

    localparam int unsigned PW      = CW + LUMA_SHIFT;
    localparam int unsigned SH      = CW - OW;
    localparam bit          DITH_EN = (DITHER != 0) && (SH >= 2);
    localparam int unsigned TSH     = (SH >= 2) ? SH - 2 : 0;
    localparam sync_t       SYNC_RST = '{de: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

    // front-end control
    logic  vs_edge_c;
    logic  vs_prev_q, vs_prev_d;
    logic  de_prev_q, de_prev_d;
    logic  px_q, px_d;
    logic  py_q, py_d;
    mode_e mode_cur_q, mode_cur_d;

    // stage 1
    logic [PW-1:0] pr_q, pr_d, pg_q, pg_d, pb_q, pb_d;
    logic [CW-1:0] r1_q, r1_d, g1_q, g1_d, b1_q, b1_d;
    sync_t         sync1_q, sync1_d;
    logic          px1_q, px1_d, py1_q, py1_d;
    mode_e         mode1_q, mode1_d;

    // stage 2
    logic [PW-1:0] sum_c;
    logic [CW-1:0] y_c;
    logic [CW-1:0] r2_q, r2_d, g2_q, g2_d, b2_q, b2_d;
    sync_t         sync2_q, sync2_d;
    logic          px2_q, px2_d, py2_q, py2_d;

    // stage 3
    logic [CW-1:0] thr_c;
    logic          blank_c;
    logic [OW-1:0] r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;
    sync_t         sync3_q, sync3_d;

    // Frame-boundary mode latch and dither raster position
    always_comb begin
        vs_edge_c  = (vs_in == SYNC_POL) && (vs_prev_q != SYNC_POL);
        vs_prev_d  = vs_in;
        de_prev_d  = de_in;
        mode_cur_d = vs_edge_c ? map_mode(mode_req) : mode_cur_q;
        px_d       = de_in ? ~px_q : 1'b0;
        py_d       = py_q;
        if (vs_edge_c) begin
            py_d = 1'b0;
        end else if (de_prev_q && !de_in) begin
            py_d = ~py_q;
        end
    end

    // Stage 1: capture pixel, weighted luma products and the mode in force for this pixel
    always_comb begin
        pr_d    = PW'(r_in) * PW'(COEF_R);
        pg_d    = PW'(g_in) * PW'(COEF_G);
        pb_d    = PW'(b_in) * PW'(COEF_B);
        r1_d    = r_in;
        g1_d    = g_in;
        b1_d    = b_in;
        sync1_d = '{de: de_in, hs: hs_in, vs: vs_in};
        px1_d   = px_q;
        py1_d   = py_q;
        mode1_d = mode_cur_d;
    end

    // Stage 2: luma and per-mode tint (coefficients sum to 255, so Y never overflows CW)
    always_comb begin
        sum_c   = pr_q + pg_q + pb_q;
        y_c     = CW'(sum_c >> LUMA_SHIFT);
        r2_d    = r1_q;
        g2_d    = g1_q;
        b2_d    = b1_q;
        case (mode1_q)
            MODE_GREEN: begin
                r2_d = '0;
                g2_d = y_c;
                b2_d = '0;
            end
            MODE_AMBER: begin
                r2_d = y_c;
                g2_d = y_c >> 1;
                b2_d = '0;
            end
            MODE_WHITE: begin
                r2_d = y_c;
                g2_d = y_c;
                b2_d = y_c;
            end
            MODE_INVERSE: begin
                r2_d = ~y_c;
                g2_d = ~y_c;
                b2_d = ~y_c;
            end
            default: ;
        endcase
        sync2_d = sync1_q;
        px2_d   = px1_q;
        py2_d   = py1_q;
    end

    // Stage 3: dither threshold and blanking for the three channel truncators
    always_comb begin
        thr_c   = DITH_EN ? (CW'(bayer_thresh(py2_q, px2_q)) << TSH) : '0;
        blank_c = ~sync2_q.de;
        sync3_d = sync2_q;
    end

    mono_dither_trunc #(.CW(CW), .OW(OW)) u_trunc_r (
        .c_in     (r2_q),
        .t_in     (thr_c),
        .blank_in (blank_c),
        .c_out_c  (r_out_d)
    );

    mono_dither_trunc #(.CW(CW), .OW(OW)) u_trunc_g (
        .c_in     (g2_q),
        .t_in     (thr_c),
        .blank_in (blank_c),
        .c_out_c  (g_out_d)
    );

    mono_dither_trunc #(.CW(CW), .OW(OW)) u_trunc_b (
        .c_in     (b2_q),
        .t_in     (thr_c),
        .blank_in (blank_c),
        .c_out_c  (b_out_d)
    );

    // All pipeline and control state
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q  <= ~SYNC_POL;
            de_prev_q  <= 1'b0;
            px_q       <= 1'b0;
            py_q       <= 1'b0;
            mode_cur_q <= MODE_COLOR;
            pr_q       <= '0;
            pg_q       <= '0;
            pb_q       <= '0;
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            sync1_q    <= SYNC_RST;
            px1_q      <= 1'b0;
            py1_q      <= 1'b0;
            mode1_q    <= MODE_COLOR;
            r2_q       <= '0;
            g2_q       <= '0;
            b2_q       <= '0;
            sync2_q    <= SYNC_RST;
            px2_q      <= 1'b0;
            py2_q      <= 1'b0;
            r_out_q    <= '0;
            g_out_q    <= '0;
            b_out_q    <= '0;
            sync3_q    <= SYNC_RST;
        end else begin
            vs_prev_q  <= vs_prev_d;
            de_prev_q  <= de_prev_d;
            px_q       <= px_d;
            py_q       <= py_d;
            mode_cur_q <= mode_cur_d;
            pr_q       <= pr_d;
            pg_q       <= pg_d;
            pb_q       <= pb_d;
            r1_q       <= r1_d;
            g1_q       <= g1_d;
            b1_q       <= b1_d;
            sync1_q    <= sync1_d;
            px1_q      <= px1_d;
            py1_q      <= py1_d;
            mode1_q    <= mode1_d;
            r2_q       <= r2_d;
            g2_q       <= g2_d;
            b2_q       <= b2_d;
            sync2_q    <= sync2_d;
            px2_q      <= px2_d;
            py2_q      <= py2_d;
            r_out_q    <= r_out_d;
            g_out_q    <= g_out_d;
            b_out_q    <= b_out_d;
            sync3_q    <= sync3_d;
        end
    end

    assign r_out    = r_out_q;
    assign g_out    = g_out_q;
    assign b_out    = b_out_q;
    assign de_out   = sync3_q.de;
    assign hs_out   = sync3_q.hs;
    assign vs_out   = sync3_q.vs;
    assign mode_cur = mode_cur_q;

endmodule
